// File: rtl/bus_writeback_demux.sv
// Takes a result-bus word, narrows it to NARROW_W bits and commits it to either
// the PC load port or a register-file write port through a 3-state buffer FSM.
module bus_writeback_demux #(
   parameter int DATA_W   = 16,
   parameter int NARROW_W = 5,
   parameter int RADDR_W  = 3,
   parameter int ERRCNT_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_data,
   input  logic                in_select,
   input  logic [RADDR_W-1:0]  in_raddr,
   input  logic                wb_stall,
   output logic                pc_we,
   output logic [NARROW_W-1:0] pc_data,
   output logic                rf_we,
   output logic [RADDR_W-1:0]  rf_addr,
   output logic [NARROW_W-1:0] rf_data,
   output logic                trunc_err,
   output logic [ERRCNT_W-1:0] err_count,
   input  logic                err_clear
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HOLD   = 2'd1,
      S_COMMIT = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [DATA_W-1:0]     buf_data_q, buf_data_d;
   logic                  buf_sel_q, buf_sel_d;
   logic [RADDR_W-1:0]    buf_raddr_q, buf_raddr_d;
   logic [NARROW_W-1:0]   narrow_q, narrow_d;
   logic                  trunc_q, trunc_d;
   logic                  pc_we_q, pc_we_d;
   logic [NARROW_W-1:0]   pc_data_q, pc_data_d;
   logic                  rf_we_q, rf_we_d;
   logic [RADDR_W-1:0]    rf_addr_q, rf_addr_d;
   logic [NARROW_W-1:0]   rf_data_q, rf_data_d;
   logic                  trunc_err_q, trunc_err_d;
   logic [ERRCNT_W-1:0]   err_count_q, err_count_d;

   always_comb begin
      // NOTE: every _d gets a default first so no path through the case infers a latch.
      state_d     = state_q;
      buf_data_d  = buf_data_q;
      buf_sel_d   = buf_sel_q;
      buf_raddr_d = buf_raddr_q;
      narrow_d    = narrow_q;
      trunc_d     = trunc_q;
      pc_we_d     = 1'b0;
      rf_we_d     = 1'b0;
      trunc_err_d = 1'b0;
      pc_data_d   = pc_data_q;
      rf_addr_d   = rf_addr_q;
      rf_data_d   = rf_data_q;
      err_count_d = err_count_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               buf_data_d  = in_data;
               buf_sel_d   = in_select;
               buf_raddr_d = in_raddr;
               state_d     = S_HOLD;
            end
         end
         S_HOLD: begin
            narrow_d = buf_data_q[NARROW_W-1:0];
            trunc_d  = |buf_data_q[DATA_W-1:NARROW_W];
            state_d  = S_COMMIT;
         end
         S_COMMIT: begin
            if (!wb_stall) begin
               if (buf_sel_q) begin
                  rf_we_d   = 1'b1;
                  rf_addr_d = buf_raddr_q;
                  rf_data_d = narrow_q;
               end else begin
                  pc_we_d   = 1'b1;
                  pc_data_d = narrow_q;
               end
               trunc_err_d = trunc_q;
               if (trunc_q && (err_count_q != '1))
                  err_count_d = err_count_q + ERRCNT_W'(1);
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Clear wins over a same-cycle increment.
      if (err_clear)
         err_count_d = '0;
   end

   // NOTE: sequential state uses non-blocking assignments only; the buffer is a
   // handful of flops, so it is reset along with everything else.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         buf_data_q  <= '0;
         buf_sel_q   <= 1'b0;
         buf_raddr_q <= '0;
         narrow_q    <= '0;
         trunc_q     <= 1'b0;
         pc_we_q     <= 1'b0;
         pc_data_q   <= '0;
         rf_we_q     <= 1'b0;
         rf_addr_q   <= '0;
         rf_data_q   <= '0;
         trunc_err_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         buf_data_q  <= buf_data_d;
         buf_sel_q   <= buf_sel_d;
         buf_raddr_q <= buf_raddr_d;
         narrow_q    <= narrow_d;
         trunc_q     <= trunc_d;
         pc_we_q     <= pc_we_d;
         pc_data_q   <= pc_data_d;
         rf_we_q     <= rf_we_d;
         rf_addr_q   <= rf_addr_d;
         rf_data_q   <= rf_data_d;
         trunc_err_q <= trunc_err_d;
         err_count_q <= err_count_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign pc_we     = pc_we_q;
   assign pc_data   = pc_data_q;
   assign rf_we     = rf_we_q;
   assign rf_addr   = rf_addr_q;
   assign rf_data   = rf_data_q;
   assign trunc_err = trunc_err_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_bus_writeback_demux.sv
// Directed bench for bus_writeback_demux: a table of single-word transactions
// plus hand sequences for stall, saturation/clear and mid-operation reset.
module tb_bus_writeback_demux;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        in_select;
   logic [2:0]  in_raddr;
   logic        wb_stall;
   logic        pc_we;
   logic [4:0]  pc_data;
   logic        rf_we;
   logic [2:0]  rf_addr;
   logic [4:0]  rf_data;
   logic        trunc_err;
   logic [3:0]  err_count;
   logic        err_clear;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bus_writeback_demux dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_select (in_select),
      .in_raddr  (in_raddr),
      .wb_stall  (wb_stall),
      .pc_we     (pc_we),
      .pc_data   (pc_data),
      .rf_we     (rf_we),
      .rf_addr   (rf_addr),
      .rf_data   (rf_data),
      .trunc_err (trunc_err),
      .err_count (err_count),
      .err_clear (err_clear)
   );

   typedef struct {
      logic [15:0] data;
      logic        sel;
      logic [2:0]  raddr;
      int          stall;
      logic        clr;
      logic [4:0]  exp_pc_data;
      logic [2:0]  exp_rf_addr;
      logic [4:0]  exp_rf_data;
      logic        exp_trunc;
      logic [3:0]  exp_err;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Runs one word through IDLE->HOLD->COMMIT(+stall)->strobe; starts and ends at a negedge in IDLE.
   task automatic run_word(input vec_t v);
      in_valid  = 1'b1;
      in_data   = v.data;
      in_select = v.sel;
      in_raddr  = v.raddr;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("ready_hold", in_ready, 0);
      @(posedge clk);
      @(negedge clk);
      check("ready_commit", in_ready, 0);
      check("no_strobe_pre", {pc_we, rf_we}, 0);
      wb_stall = (v.stall > 0);
      for (int i = 0; i < v.stall; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("stalled_strobes", {pc_we, rf_we, trunc_err}, 0);
         check("stalled_ready", in_ready, 0);
      end
      wb_stall  = 1'b0;
      err_clear = v.clr;
      @(posedge clk);
      @(negedge clk);
      err_clear = 1'b0;
      check("pc_we", pc_we, !v.sel);
      check("rf_we", rf_we, v.sel);
      check("pc_data", pc_data, v.exp_pc_data);
      check("rf_addr", rf_addr, v.exp_rf_addr);
      check("rf_data", rf_data, v.exp_rf_data);
      check("trunc_err", trunc_err, v.exp_trunc);
      check("err_count", err_count, v.exp_err);
      check("ready_after", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      check("strobe_one_cycle", {pc_we, rf_we, trunc_err}, 0);
   endtask

   initial begin
      vec_t v;

      //          data      sel   ra    stl clr  pc     rfa   rfd    tr    err
      vecs[0] = '{16'h0013, 1'b0, 3'd0, 0, 1'b0, 5'h13, 3'd0, 5'h00, 1'b0, 4'd0};
      vecs[1] = '{16'h001F, 1'b1, 3'd5, 0, 1'b0, 5'h13, 3'd5, 5'h1F, 1'b0, 4'd0};
      vecs[2] = '{16'h8021, 1'b0, 3'd0, 0, 1'b0, 5'h01, 3'd5, 5'h1F, 1'b1, 4'd1};
      vecs[3] = '{16'hFFE2, 1'b1, 3'd7, 2, 1'b0, 5'h01, 3'd7, 5'h02, 1'b1, 4'd2};
      vecs[4] = '{16'h0020, 1'b0, 3'd3, 0, 1'b0, 5'h00, 3'd7, 5'h02, 1'b1, 4'd3};
      vecs[5] = '{16'h001E, 1'b1, 3'd0, 1, 1'b0, 5'h00, 3'd0, 5'h1E, 1'b0, 4'd3};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_select = 1'b0;
      in_raddr  = '0;
      wb_stall  = 1'b0;
      err_clear = 1'b0;
      #2;
      check("rst_ready", in_ready, 1);
      check("rst_strobes", {pc_we, rf_we, trunc_err}, 0);
      check("rst_data", {pc_data, rf_addr, rf_data}, 0);
      check("rst_err", err_count, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++)
         run_word(vecs[i]);

      // Stall for 4 cycles with a second word offered that must be ignored.
      in_valid  = 1'b1;
      in_data   = 16'h0009;
      in_select = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      wb_stall  = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'h0011;
      in_select = 1'b1;
      in_raddr  = 3'd4;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("stall_no_strobe", {pc_we, rf_we}, 0);
         check("stall_ready", in_ready, 0);
      end
      wb_stall = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("stall_pc_we", pc_we, 1);
      check("stall_pc_data", pc_data, 5'h09);
      check("stall_rf_we", rf_we, 0);
      check("stall_rf_hold", {rf_addr, rf_data}, {3'd0, 5'h1E});
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("second_word_ignored", {pc_we, rf_we}, 0);
      end

      // Clear while idle.
      err_clear = 1'b1;
      @(posedge clk);
      @(negedge clk);
      err_clear = 1'b0;
      check("clear_idle", err_count, 0);

      // 17 truncating words saturate the counter at 15.
      for (int i = 0; i < 17; i++) begin
         v = '{16'h0100 + 16'(i), 1'b0, 3'd0, 0, 1'b0, 5'(i), 3'd0, 5'h1E, 1'b1,
               4'((i + 1 > 15) ? 15 : i + 1)};
         run_word(v);
      end
      // 18th truncating commit with a same-cycle clear reads 0.
      v = '{16'h0140, 1'b0, 3'd0, 0, 1'b1, 5'h00, 3'd0, 5'h1E, 1'b1, 4'd0};
      run_word(v);
      v = '{16'h0203, 1'b0, 3'd0, 0, 1'b0, 5'h03, 3'd0, 5'h1E, 1'b1, 4'd1};
      run_word(v);

      // Asynchronous reset while in HOLD.
      in_valid  = 1'b1;
      in_data   = 16'h0015;
      in_select = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("pre_rst_ready", in_ready, 0);
      rst_n = 1'b0;
      #1;
      check("arst_ready", in_ready, 1);
      check("arst_strobes", {pc_we, rf_we, trunc_err}, 0);
      check("arst_data", {pc_data, rf_addr, rf_data}, 0);
      check("arst_err", err_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("post_rst_no_strobe", {pc_we, rf_we}, 0);
         check("post_rst_ready", in_ready, 1);
      end
      v = '{16'h0004, 1'b1, 3'd6, 0, 1'b0, 5'h00, 3'd6, 5'h04, 1'b0, 4'd0};
      run_word(v);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/bus_writeback_demux.md
Name: bus_writeback_demux

Overview:
- Receive-side counterpart of the PC/regA source mux. The mux zero-extends a 5-bit PC or regA value onto the 16-bit result bus; this block takes a 16-bit result back off that bus, narrows it to 5 bits, and routes it to either the PC load port or a register-file write port.
- Single-entry buffer with valid/ready handshake, a 3-state commit FSM, stall support and truncation-error tracking.
- Sits between the datapath result bus and the PC / register-file write ports.

Parameters:
- DATA_W, 16, result-bus width.
- NARROW_W, 5, PC / register data width; must be less than DATA_W.
- RADDR_W, 3, register-file address width.
- ERRCNT_W, 4, width of the saturating truncation-error counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  result-bus word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  DATA_W  result-bus word.
- in_select  in  1  destination: 0 = PC, 1 = register file (same encoding as the source mux).
- in_raddr  in  RADDR_W  destination register when in_select = 1.
- wb_stall  in  1  downstream stall; holds the commit.
- pc_we  out  1  PC load strobe.
- pc_data  out  NARROW_W  PC load value.
- rf_we  out  1  register-file write strobe.
- rf_addr  out  RADDR_W  register-file write address.
- rf_data  out  NARROW_W  register-file write data.
- trunc_err  out  1  one-cycle pulse: the committed word had nonzero bits above NARROW_W.
- err_count  out  ERRCNT_W  saturating count of truncation events.
- err_clear  in  1  synchronous clear of err_count.

Behaviour:
- Reset (rst_n low, asynchronous): FSM to IDLE; in_ready=1. pc_we, rf_we, trunc_err=0. pc_data, rf_data, rf_addr=0. err_count=0. Buffer cleared.
- Reset asserted mid-operation discards the buffered word; no write strobe is issued.
- IDLE:
  - in_ready=1.
  - On in_valid: capture in_data, in_select, in_raddr into the buffer; go to HOLD.
- HOLD:
  - in_ready=0.
  - Register narrow = buf[NARROW_W-1:0] and trunc = |buf[DATA_W-1:NARROW_W]; go to COMMIT.
- COMMIT:
  - in_ready=0.
  - If wb_stall=1: stay in COMMIT; all strobes 0.
  - Else, for exactly one cycle: if select=0, pc_we=1 and pc_data=narrow; if select=1, rf_we=1, rf_addr=raddr, rf_data=narrow. Also trunc_err=trunc. Then go to IDLE.
- Write strobes are mutually exclusive and never asserted outside COMMIT.
- Data outputs hold their last committed values between strobes.
- Latency: a word accepted at edge N produces its strobe in the cycle after edge N+2 (no stall). Throughput is one word per 3 cycles.
- Truncation:
  - The write is still performed with the low NARROW_W bits.
  - err_count increments on each commit with trunc=1 and saturates at all-ones.
  - err_clear has priority over a same-cycle increment: the result is 0.
- in_valid while in_ready=0 is ignored; the upstream must hold in_data until accepted.
- wb_stall outside COMMIT has no effect.

Test Plan:
- Reset then in_valid=1, in_data=16'h0013, in_select=0 -> pc_we=1 with pc_data=5'h13 exactly 3 cycles later; rf_we stays 0; trunc_err=0.
- in_data=16'h001F, in_select=1, in_raddr=3'd5 -> rf_we=1, rf_addr=5, rf_data=5'h1F for one cycle; in_ready=0 during HOLD/COMMIT and back to 1 the next cycle.
- in_data=16'h8021, in_select=0 -> pc_data=5'h01, trunc_err pulse coincident with pc_we, err_count=1.
- wb_stall held for 4 cycles during COMMIT -> no strobe while stalled; strobe appears in the cycle stall drops; a second in_valid during the stall is not accepted.
- 17 truncating words, then err_clear asserted together with an 18th truncating commit -> err_count saturates at 15, then reads 0.
- rst_n driven low while in HOLD -> no strobe; outputs and err_count return to 0 asynchronously; in_ready=1 after release.
